// File: rtl/ex_commit.sv
// Commit/writeback stage: round-robin arbitration across execute-unit results
// into a one-entry output register feeding the register-file write port and scoreboard clear.
module ex_commit #(
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RN_W      = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        ex_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] ex_result,
    input  logic [NUM_UNITS*RN_W-1:0]   ex_rd,
    output logic [NUM_UNITS-1:0]        ex_stall,
    output logic                        rf_we,
    output logic [RN_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    input  logic                        rf_stall,
    output logic                        sb_clear,
    output logic [RN_W-1:0]             sb_clear_rn
);

    localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                 full;
    logic                 we_q;
    logic [RN_W-1:0]      rd_q;
    logic [DATA_W-1:0]    data_q;
    logic [PTR_W-1:0]     ptr;

    logic                 drain;
    logic                 accept;
    logic                 any_valid;
    logic [NUM_UNITS-1:0] grant;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     ptr_nxt;
    logic [PTR_W-1:0]     idx;
    logic [RN_W-1:0]      sel_rd;
    logic [DATA_W-1:0]    sel_data;

    assign drain  = full & ~rf_stall;
    assign accept = ~full | drain;

    // First valid unit searching upward from the pointer, with wrap.
    always_comb begin : arb
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_UNITS);
            if (!any_valid && ex_valid[idx]) begin
                any_valid      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

    always_comb begin : sel_mux
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                sel_rd   = ex_rd[i*RN_W +: RN_W];
                sel_data = ex_result[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt  = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign ex_stall = ex_valid & ~(grant & {NUM_UNITS{accept}});

    // Output entry: a grant reloads (even while draining), otherwise a drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            ptr    <= '0;
        end else if (accept && any_valid) begin
            full   <= 1'b1;
            we_q   <= (sel_rd != '0);
            rd_q   <= sel_rd;
            data_q <= sel_data;
            ptr    <= ptr_nxt;
        end else if (drain) begin
            full   <= 1'b0;
            we_q   <= 1'b0;
        end
    end

    // Writes to register 0 retire silently, so the strobe carries the rd!=0 test.
    assign rf_we       = we_q;
    assign sb_clear    = we_q;
    assign rf_waddr    = rd_q;
    assign sb_clear_rn = rd_q;
    assign rf_wdata    = data_q;

    // A stalled unit must keep its valid, result and rd stable into the next cycle.
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_proto
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            ex_stall[g] |=> (ex_valid[g]
                             && $stable(ex_result[g*DATA_W +: DATA_W])
                             && $stable(ex_rd[g*RN_W +: RN_W])));
    end

endmodule

// File: tb/tb_ex_commit.sv
// Scoreboard bench for ex_commit: producer queues per unit, a round-robin
// reference model, and an expected-commit queue compared at the write port.
module tb_ex_commit;

    localparam int NU = 3;
    localparam int DW = 64;
    localparam int RW = 6;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } item_t;

    logic             clk;
    logic             rst_n;
    logic [NU-1:0]    ex_valid;
    logic [NU*DW-1:0] ex_result;
    logic [NU*RW-1:0] ex_rd;
    logic [NU-1:0]    ex_stall;
    logic             rf_we;
    logic [RW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic             rf_stall;
    logic             sb_clear;
    logic [RW-1:0]    sb_clear_rn;

    ex_commit #(.NUM_UNITS(NU), .DATA_W(DW), .RN_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_result  (ex_result),
        .ex_rd      (ex_rd),
        .ex_stall   (ex_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_stall   (rf_stall),
        .sb_clear   (sb_clear),
        .sb_clear_rn(sb_clear_rn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    item_t uq[NU][$];
    item_t exp_q[$];
    int    mptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int u, input int rd, input logic [63:0] d);
        item_t it;
        it.rd   = RW'(rd);
        it.data = d;
        uq[u].push_back(it);
    endtask

    task automatic drive(input logic st);
        for (int i = 0; i < NU; i++) begin
            ex_valid[i] = (uq[i].size() > 0);
            if (uq[i].size() > 0) begin
                ex_result[i*DW +: DW] = uq[i][0].data;
                ex_rd[i*RW +: RW]     = uq[i][0].rd;
            end
        end
        rf_stall = st;
    endtask

    // One clock: drive after the edge, check at the falling edge, retire model after the next edge.
    task automatic cycle(input logic st);
        logic          drn;
        logic          acc;
        int            g;
        int            ix;
        logic [NU-1:0] es;
        drive(st);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check("rf_we", rf_we, exp_q[0].rd != 0);
            check("sb_clear", sb_clear, exp_q[0].rd != 0);
            if (exp_q[0].rd != 0) begin
                check("rf_waddr", rf_waddr, exp_q[0].rd);
                check("rf_wdata", rf_wdata, exp_q[0].data);
                check("sb_clear_rn", sb_clear_rn, exp_q[0].rd);
            end
        end else begin
            check("rf_we_idle", rf_we, 0);
            check("sb_clear_idle", sb_clear, 0);
        end
        drn = (exp_q.size() > 0) && !st;
        acc = (exp_q.size() == 0) || drn;
        g = -1;
        for (int k = 0; k < NU; k++) begin
            ix = (mptr + k) % NU;
            if (g < 0 && ex_valid[ix]) g = ix;
        end
        es = ex_valid;
        if (acc && g >= 0) es[g] = 1'b0;
        check("ex_stall", ex_stall, es);
        @(posedge clk);
        #1;
        if (drn) void'(exp_q.pop_front());
        if (acc && g >= 0) begin
            exp_q.push_back(uq[g][0]);
            void'(uq[g].pop_front());
            mptr = (g + 1) % NU;
        end
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() > 0);
        for (int i = 0; i < NU; i++) if (uq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    initial begin
        int guard;
        rst_n     = 1'b0;
        ex_valid  = '0;
        ex_result = '0;
        ex_rd     = '0;
        rf_stall  = 1'b0;

        // Reset with no unit valid.
        repeat (3) begin
            @(negedge clk);
            check("rst_rf_we", rf_we, 0);
            check("rst_sb_clear", sb_clear, 0);
            check("rst_ex_stall", ex_stall, 0);
            check("rst_rf_waddr", rf_waddr, 0);
            check("rst_rf_wdata", rf_wdata, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0);

        // Single result from unit 0.
        push(0, 5, 64'h1234);
        repeat (3) cycle(1'b0);

        // All units streaming, rd 1/2/3.
        for (int r = 0; r < 4; r++)
            for (int u = 0; u < NU; u++) push(u, u + 1, 64'(64'hC000 + r * 16 + u));
        repeat (15) cycle(1'b0);

        // Entry rd=7 held under rf_stall while unit 1 waits.
        push(0, 7, 64'hA7);
        cycle(1'b0);
        push(1, 9, 64'hB9);
        repeat (3) cycle(1'b1);
        repeat (3) cycle(1'b0);

        // Write to register 0 retires silently.
        push(2, 0, 64'hFFFF);
        repeat (3) cycle(1'b0);

        // Reset mid-operation with the entry full and stalled.
        push(0, 10, 64'hAA);
        cycle(1'b0);
        push(1, 11, 64'hBB);
        push(2, 12, 64'hCC);
        cycle(1'b1);
        drive(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rf_we", rf_we, 0);
        check("async_rst_sb_clear", sb_clear, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NU; i++) uq[i].delete();
        exp_q.delete();
        mptr = 0;
        drive(1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(2, 12, 64'hCC);
        push(1, 11, 64'hBB);
        repeat (4) cycle(1'b0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 300; c++) begin
            for (int u = 0; u < NU; u++)
                if ($urandom_range(0, 2) == 0 && uq[u].size() < 4)
                    push(u, int'($urandom_range(0, 63)), {$urandom(), $urandom()});
            cycle($urandom_range(0, 3) == 0);
        end
        guard = 0;
        while (busy() && guard < 100) begin
            cycle(1'b0);
            guard++;
        end
        check("drain_timeout", guard < 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
